// File: rtl/ace_pkg.sv
// Shared fetch/decode definitions: instruction word layout, halt opcode and
// the {data, pc} entry held in the prefetch buffer.
package ace_pkg;

    localparam int INST_WIDTH   = 32;
    localparam int OPCODE_MSB   = 31;
    localparam int OPCODE_LSB   = 28;
    localparam int PC_MAX_WIDTH = 32;

    localparam logic [OPCODE_MSB-OPCODE_LSB:0] OPCODE_HALT = 4'hF;

    typedef logic [INST_WIDTH-1:0] inst_word_t;

    // pc is sized for the widest supported address bus; narrower buses zero-extend.
    typedef struct packed {
        inst_word_t              data;
        logic [PC_MAX_WIDTH-1:0] pc;
    } fetch_entry_t;

    function automatic logic is_halt_opcode(input inst_word_t word);
        return word[OPCODE_MSB:OPCODE_LSB] == OPCODE_HALT;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer of {data, pc} entries: synchronous FIFO with flush and an
// occupancy count. Overflow is prevented by the caller's issue throttling.
module fetch_fifo
    import ace_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  fetch_entry_t     push_entry_i,
    input  logic             pop_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_en;
    logic             pop_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign push_en = push_i && !flush_i;
    assign pop_en  = pop_i && !empty_o && !flush_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop_en) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so the head presents zeros until the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_en) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, issues in-order word reads and buffers
// responses for the decoder. Optional halt-on-opcode-F: INSTRUCTION_FETCH_HALT_EN.
module instruction_fetch
    import ace_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    FIFO_DEPTH = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_resp_valid,
    input  logic [INST_WIDTH-1:0] mem_resp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc
`ifdef INSTRUCTION_FETCH_HALT_EN
    ,
    output logic                  halted
`endif
);

    localparam int             CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

    logic                    run_q;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]   resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]        out_q, out_d;
    logic [CNT_W-1:0]        stale_q, stale_d;
    logic [CNT_W-1:0]        fifo_cnt;
    logic                    fifo_empty;
    logic [CNT_W:0]          live;
    logic                    req_fire;
    logic                    resp_fire;
    logic                    resp_stale;
    logic                    push;
    logic                    pop;
    logic                    halt_stop;
    fetch_entry_t            push_entry;
    fetch_entry_t            head;
    logic [PC_MAX_WIDTH-1:0] head_pc;

`ifdef INSTRUCTION_FETCH_HALT_EN
    logic halted_q, halted_d;

    always_comb begin
        halted_d = halted_q;
        if (redirect_valid) begin
            halted_d = 1'b0;
        end else if (push && is_halt_opcode(mem_resp_data)) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign halt_stop = halted_q;
    assign halted    = halted_q;
`else
    assign halt_stop = 1'b0;
`endif

    // live = words that will occupy the buffer once every non-stale response lands.
    always_comb begin
        live          = (CNT_W + 1)'(fifo_cnt) + (CNT_W + 1)'(out_q) - (CNT_W + 1)'(stale_q);
        mem_req_valid = run_q && !halt_stop && (live < DEPTH_LIM);
        req_fire      = mem_req_valid && mem_req_ready;
        resp_fire     = mem_resp_valid && (out_q != '0);
        resp_stale    = resp_fire && (stale_q != '0);
        push          = resp_fire && !resp_stale && !redirect_valid;
        pop           = inst_valid && inst_ready;
        out_d         = out_q + CNT_W'(req_fire) - CNT_W'(resp_fire);

        pc_d      = req_fire ? pc_q + ADDR_WIDTH'(1) : pc_q;
        resp_pc_d = push ? resp_pc_q + ADDR_WIDTH'(1) : resp_pc_q;
        stale_d   = stale_q - CNT_W'(resp_stale);
        // Every request still unanswered after this edge belongs to the old stream.
        if (redirect_valid) begin
            pc_d      = redirect_pc;
            resp_pc_d = redirect_pc;
            stale_d   = out_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q     <= 1'b0;
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            out_q     <= '0;
            stale_q   <= '0;
        end else begin
            run_q     <= 1'b1;
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            out_q     <= out_d;
            stale_q   <= stale_d;
        end
    end

    assign push_entry = '{data: mem_resp_data, pc: PC_MAX_WIDTH'(resp_pc_q)};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fetch_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (redirect_valid),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (fifo_cnt),
        .empty_o      (fifo_empty)
    );

    assign mem_req_addr = pc_q;
    assign inst_valid   = !fifo_empty;
    assign inst_data    = head.data;
    assign head_pc      = head.pc;
    assign inst_pc      = ADDR_WIDTH'(head_pc);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: per-cycle vector table for the
// stream/backpressure case plus hand sequences for redirect, wrap and halt.
module tb_instruction_fetch;

    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_resp_valid;
    logic [31:0]   mem_resp_data;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   inst_data;
    logic [AW-1:0] inst_pc;
`ifdef INSTRUCTION_FETCH_HALT_EN
    logic          halted;
`endif

    always #5 clk = ~clk;

    instruction_fetch #(
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (8'h10)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
`ifdef INSTRUCTION_FETCH_HALT_EN
        ,
        .halted         (halted)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Memory model: fixed latency, always ready, word content derived from address.
    int            lat    = 1;
    bit            hmode  = 1'b0;
    int            ncyc   = 0;
    int            accepts = 0;
    logic [AW-1:0] q_addr[$];
    int            q_due[$];

    function automatic logic [31:0] word(input logic [7:0] a);
        return (hmode && a == 8'h05) ? 32'hF000_0000 : {4'h1, 12'h0A5, 8'h00, a};
    endfunction

    always @(negedge clk) begin
        ncyc++;
        if (!rst_n) begin
            q_addr.delete();
            q_due.delete();
            mem_resp_valid = 1'b0;
        end else begin
            mem_resp_valid = 1'b0;
            if (q_due.size() > 0 && q_due[0] == ncyc) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = word(q_addr[0]);
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end
            if (mem_req_valid && mem_req_ready) begin
                q_addr.push_back(mem_req_addr);
                q_due.push_back(ncyc + lat);
                accepts++;
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Leaves the bench at the negedge where rst_n rises (cycle 0).
    task automatic do_reset(input int l, input bit hm);
        @(negedge clk);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        lat            = l;
        hmode          = hm;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_redirect(input logic [AW-1:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic collect(input string nm, input logic [7:0] first, input int n, input int budget);
        logic [7:0] e   = first;
        int         got = 0;
        int         cyc = 0;
        while (got < n && cyc < budget) begin
            if (inst_valid && inst_ready) begin
                check({nm, "_pc"}, 32'(inst_pc), 32'(e));
                check({nm, "_data"}, inst_data, word(e));
                e++;
                got++;
            end
            step();
            cyc++;
        end
        if (got < n) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout delivered=%0d required=%0d", nm, got, n);
        end
    endtask

    typedef struct {
        bit         ir;
        bit         rv;
        logic [7:0] addr;
        bit         iv;
        logic [7:0] pc;
    } vec_t;

    vec_t tbl [16];

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;

        // Stream from 0x10 with 1-cycle memory, then a stall window.
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 1'b1, 8'h10, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 1'b1, 8'h11, 1'b0, 8'h00};
        tbl[3]  = '{1'b1, 1'b1, 8'h12, 1'b1, 8'h10};
        tbl[4]  = '{1'b1, 1'b1, 8'h13, 1'b1, 8'h11};
        tbl[5]  = '{1'b1, 1'b1, 8'h14, 1'b1, 8'h12};
        tbl[6]  = '{1'b1, 1'b1, 8'h15, 1'b1, 8'h13};
        tbl[7]  = '{1'b1, 1'b1, 8'h16, 1'b1, 8'h14};
        tbl[8]  = '{1'b0, 1'b1, 8'h17, 1'b1, 8'h15};
        tbl[9]  = '{1'b0, 1'b1, 8'h18, 1'b1, 8'h15};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h15};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h15};
        tbl[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h15};
        tbl[13] = '{1'b1, 1'b1, 8'h19, 1'b1, 8'h16};
        tbl[14] = '{1'b1, 1'b1, 8'h1A, 1'b1, 8'h17};
        tbl[15] = '{1'b1, 1'b1, 8'h1B, 1'b1, 8'h18};

        @(negedge clk);
        check("reset_req_valid", 32'(mem_req_valid), 32'd0);
        check("reset_inst_valid", 32'(inst_valid), 32'd0);
        check("reset_inst_data", inst_data, 32'd0);
        check("reset_inst_pc", 32'(inst_pc), 32'd0);
`ifdef INSTRUCTION_FETCH_HALT_EN
        check("reset_halted", 32'(halted), 32'd0);
`endif

        do_reset(1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            inst_ready = tbl[i].ir;
            check($sformatf("row%0d_req_valid", i), 32'(mem_req_valid), 32'(tbl[i].rv));
            if (tbl[i].rv) begin
                check($sformatf("row%0d_req_addr", i), 32'(mem_req_addr), 32'(tbl[i].addr));
            end
            check($sformatf("row%0d_inst_valid", i), 32'(inst_valid), 32'(tbl[i].iv));
            if (tbl[i].iv) begin
                check($sformatf("row%0d_inst_pc", i), 32'(inst_pc), 32'(tbl[i].pc));
                check($sformatf("row%0d_inst_data", i), inst_data, word(tbl[i].pc));
            end
            step();
        end

        // Asynchronous reset in the middle of a cycle clears outputs at once.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_req_valid", 32'(mem_req_valid), 32'd0);
        check("async_inst_valid", 32'(inst_valid), 32'd0);
        check("async_inst_pc", 32'(inst_pc), 32'd0);
        check("async_inst_data", inst_data, 32'd0);

        // Redirect while two requests are in flight on a 3-cycle memory.
        do_reset(3, 1'b0);
        inst_ready = 1'b1;
        step();
        step();
        pulse_redirect(8'h40);
        check("redir_req_valid", 32'(mem_req_valid), 32'd1);
        check("redir_req_addr", 32'(mem_req_addr), 32'h40);
        check("redir_inst_valid", 32'(inst_valid), 32'd0);
        collect("redir", 8'h40, 3, 30);

        // Redirect coinciding with a response, a consumed instruction and an accepted request.
        do_reset(1, 1'b0);
        inst_ready = 1'b1;
        repeat (5) step();
        check("simul_consumed_valid", 32'(inst_valid), 32'd1);
        check("simul_consumed_pc", 32'(inst_pc), 32'h12);
        check("simul_req_valid", 32'(mem_req_valid), 32'd1);
        pulse_redirect(8'h80);
        check("simul_inst_valid", 32'(inst_valid), 32'd0);
        check("simul_req_addr", 32'(mem_req_addr), 32'h80);
        collect("simul", 8'h80, 4, 20);

        // PC wraps modulo 2^ADDR_WIDTH.
        pulse_redirect(8'hFE);
        collect("wrap", 8'hFE, 4, 20);

`ifdef INSTRUCTION_FETCH_HALT_EN
        begin
            int a0;
            do_reset(1, 1'b1);
            inst_ready = 1'b1;
            step();
            pulse_redirect(8'h02);
            collect("halt_pre", 8'h02, 4, 20);
            repeat (4) step();
            a0 = accepts;
            repeat (4) step();
            check("halt_flag", 32'(halted), 32'd1);
            check("halt_req_valid", 32'(mem_req_valid), 32'd0);
            check("halt_no_accepts", 32'(accepts - a0), 32'd0);
            pulse_redirect(8'h00);
            check("halt_cleared", 32'(halted), 32'd0);
            check("halt_resume_req", 32'(mem_req_valid), 32'd1);
            check("halt_resume_addr", 32'(mem_req_addr), 32'h00);
            collect("halt_resume", 8'h00, 2, 20);
        end
`else
        do_reset(1, 1'b1);
        inst_ready = 1'b1;
        step();
        pulse_redirect(8'h04);
        collect("nohalt", 8'h04, 4, 20);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
